// File: rtl/pit_pkg.sv
// pit_pkg: shared constants for the PIT bus sequencer.
// Port indices, control-word field values and bit positions, channel decode helper.
package pit_pkg;

    localparam logic [1:0] PIT_PORT_CH0  = 2'd0;
    localparam logic [1:0] PIT_PORT_CH1  = 2'd1;
    localparam logic [1:0] PIT_PORT_CH2  = 2'd2;
    localparam logic [1:0] PIT_PORT_CTRL = 2'd3;

    localparam logic [1:0] PIT_SC_READBACK = 2'b11;
    localparam logic [1:0] PIT_RW_LATCH    = 2'b00;

    localparam int CW_SC_HI     = 7;
    localparam int CW_SC_LO     = 6;
    localparam int CW_RW_HI     = 5;
    localparam int CW_RW_LO     = 4;
    localparam int CW_MODE_HI   = 2;
    localparam int CW_MODE_LO   = 1;
    localparam int CW_RB_COUNTN = 5;
    localparam int CW_RB_CH_HI  = 3;
    localparam int CW_RB_CH_LO  = 1;

    // Channel number to one-hot strobe; index 3 (control) maps to none.
    function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
        return 3'b001 << ch;
    endfunction

endpackage

// File: rtl/pit_clk_gen.sv
// pit_clk_gen: free-running CLK_DIV divider producing the shared pit_clk.
// Ports: clk, reset_n (async, active-low) in; pit_clk out (high for counts < CLK_DIV/2).
module pit_clk_gen #(
    parameter int CLK_DIV = 42
) (
    input  logic clk,
    input  logic reset_n,
    output logic pit_clk
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_nxt;

    assign div_nxt = (div_cnt == LAST) ? '0 : div_cnt + CW'(1);

    // pit_clk is registered from the next count so it tracks div_cnt
    // while still resetting low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            pit_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pit_clk <= (div_nxt < HALF);
        end
    end

endmodule

// File: rtl/pit_controller.sv
// pit_controller: decodes PIT I/O ports 0x40-0x43 into per-channel timer strobes.
// Ports: bus (cs, data_m_*), timer strobes/shared buses, timer_count0..2, pit_clk. Macro PIT_READBACK_EN enables read-back latch.
module pit_controller
    import pit_pkg::*;
#(
    parameter int CLK_DIV = 42
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic        data_m_addr,
    input  logic [1:0]  data_m_bytesel,
    input  logic [15:0] data_m_data_in,
    output logic [15:0] data_m_data_out,
    output logic        data_m_ack,
    output logic        pit_clk,
    output logic [7:0]  timer_reload,
    output logic [1:0]  timer_rw,
    output logic [1:0]  timer_mode,
    output logic [2:0]  timer_configure,
    output logic [2:0]  timer_load,
    output logic [2:0]  timer_latch,
    output logic [2:0]  timer_read,
    input  logic [7:0]  timer_count0,
    input  logic [7:0]  timer_count1,
    input  logic [7:0]  timer_count2
);

    logic        accept;
    logic [1:0]  port;
    logic [7:0]  wbyte;
    logic [7:0]  rbyte;
    logic [1:0]  sc;
    logic [1:0]  rw;

    logic [2:0]  cfg_d;
    logic [2:0]  load_d;
    logic [2:0]  latch_d;
    logic [2:0]  read_d;
    logic [7:0]  reload_d;
    logic [1:0]  rw_d;
    logic [1:0]  mode_d;
    logic [15:0] dout_d;

    logic        unused_bits;

    // The ack register doubles as the IDLE/ACK state: no accept while acking.
    assign accept = cs & data_m_access & ~data_m_ack;
    assign port   = {data_m_addr, data_m_bytesel[1]};
    assign wbyte  = data_m_bytesel[1] ? data_m_data_in[15:8]
                                      : data_m_data_in[7:0];
    assign sc     = wbyte[CW_SC_HI:CW_SC_LO];
    assign rw     = wbyte[CW_RW_HI:CW_RW_LO];

    assign unused_bits = ^{wbyte[0], wbyte[CW_RB_CH_HI:CW_RB_CH_LO], data_m_bytesel[0]};

    always_comb begin
        unique case (1'b1)
            port == PIT_PORT_CH0: rbyte = timer_count0;
            port == PIT_PORT_CH1: rbyte = timer_count1;
            port == PIT_PORT_CH2: rbyte = timer_count2;
            default:              rbyte = 8'h00;
        endcase
    end

    always_comb begin
        cfg_d    = 3'b000;
        load_d   = 3'b000;
        latch_d  = 3'b000;
        read_d   = 3'b000;
        reload_d = timer_reload;
        rw_d     = timer_rw;
        mode_d   = timer_mode;
        dout_d   = data_m_data_out;
        if (accept) begin
            if (data_m_wr_en) begin
                if (port == PIT_PORT_CTRL) begin
                    if (sc != PIT_SC_READBACK) begin
                        if (rw == PIT_RW_LATCH) begin
                            latch_d = ch_onehot(sc);
                        end else begin
                            cfg_d  = ch_onehot(sc);
                            rw_d   = rw;
                            mode_d = wbyte[CW_MODE_HI:CW_MODE_LO];
                        end
                    end else begin
`ifdef PIT_READBACK_EN
                        // COUNT# is active-low; status latch not supported.
                        if (!wbyte[CW_RB_COUNTN])
                            latch_d = wbyte[CW_RB_CH_HI:CW_RB_CH_LO];
`endif
                    end
                end else begin
                    load_d   = ch_onehot(port);
                    reload_d = wbyte;
                end
            end else begin
                // Count captured now; timer_read fires next cycle so the
                // channel's LSB/MSB toggle advances after this byte is taken.
                read_d = ch_onehot(port);
                dout_d = {rbyte, rbyte};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_m_ack      <= 1'b0;
            data_m_data_out <= 16'h0000;
            timer_configure <= 3'b000;
            timer_load      <= 3'b000;
            timer_latch     <= 3'b000;
            timer_read      <= 3'b000;
            timer_reload    <= 8'h00;
            timer_rw        <= 2'b00;
            timer_mode      <= 2'b00;
        end else begin
            data_m_ack      <= accept;
            data_m_data_out <= dout_d;
            timer_configure <= cfg_d;
            timer_load      <= load_d;
            timer_latch     <= latch_d;
            timer_read      <= read_d;
            timer_reload    <= reload_d;
            timer_rw        <= rw_d;
            timer_mode      <= mode_d;
        end
    end

    pit_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .pit_clk (pit_clk)
    );

endmodule
